// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port request scheduler: round-robin arbitration among masters that
// decode to this slave. It holds the grant across the req/ack handshake and has a watchdog.
module xbar_slave_arbiter #(
  parameter int unsigned NM        = 2,
  parameter logic        SLAVE_ID  = 1'b0,
  parameter int unsigned TO_CYCLES = 16,
  localparam int unsigned IW       = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NM-1:0] m_req,
  input  logic [NM-1:0] m_cmd,
  input  logic [NM-1:0] m_sel,
  input  logic          s_ack,
  output logic          s_req,
  output logic          s_cmd,
  output logic [NM-1:0] m_ack,
  output logic [NM-1:0] grant,
  output logic [IW-1:0] grant_idx,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned WDW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TO_CYCLES == 0) ? '0 : WDW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic          s_req_q, s_req_d;
  logic          s_cmd_q, s_cmd_d;
  logic [NM-1:0] m_ack_q, m_ack_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  logic [NM-1:0] elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int unsigned   cand;
  logic [IW-1:0] g, g_next;
  logic          abort, expire;

  assign elig   = m_req & ~(m_sel ^ {NM{SLAVE_ID}});
  // grant_idx_q is the latched owner while BUSY/DONE
  assign g      = grant_idx_q;
  assign g_next = (g == IW'(NM - 1)) ? '0 : g + 1'b1;
  assign abort  = ~m_req[g];
  assign expire = (TO_CYCLES != 0) && (wd_q == WD_LAST);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NM) cand = cand - NM;
      if (!win_found && elig[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      wd_q          <= '0;
      s_req_q       <= 1'b0;
      s_cmd_q       <= 1'b0;
      m_ack_q       <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wd_q          <= wd_d;
      s_req_q       <= s_req_d;
      s_cmd_q       <= s_cmd_d;
      m_ack_q       <= m_ack_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: if (win_found) begin
        state_d = BUSY;
        wd_d    = '0;
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
          ptr_d   = g_next;
          wd_d    = '0;
        end else if (s_ack || expire) begin
          state_d = DONE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = g_next;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_req_d       = s_req_q;
    s_cmd_d       = s_cmd_q;
    m_ack_d       = '0;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (win_found) begin
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        grant_idx_d      = win_idx;
        s_req_d          = 1'b1;
        s_cmd_d          = m_cmd[win_idx];
        busy_d           = 1'b1;
      end
      BUSY: begin
        if (abort) begin
          s_req_d     = 1'b0;
          grant_d     = '0;
          grant_idx_d = '0;
          busy_d      = 1'b0;
        end else if (s_ack) begin
          m_ack_d[g] = 1'b1;
          s_req_d    = 1'b0;
        end else if (expire) begin
          m_ack_d[g]    = 1'b1;
          timeout_err_d = 1'b1;
          s_req_d       = 1'b0;
        end
      end
      DONE: begin
        grant_d     = '0;
        grant_idx_d = '0;
        busy_d      = 1'b0;
      end
      default: begin
        s_req_d     = 1'b0;
        grant_d     = '0;
        grant_idx_d = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign s_req       = s_req_q;
  assign s_cmd       = s_cmd_q;
  assign m_ack       = m_ack_q;
  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter (NM=2, SLAVE_ID=0, TO_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xbar_slave_arbiter;

  localparam int unsigned NM = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] m_req, m_cmd, m_sel;
  logic          s_ack;
  logic          s_req, s_cmd, busy, timeout_err;
  logic [NM-1:0] m_ack, grant;
  logic          grant_idx;

  int n_checks = 0;
  int n_pass   = 0;

  xbar_slave_arbiter #(
    .NM        (NM),
    .SLAVE_ID  (1'b0),
    .TO_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_cmd       (m_cmd),
    .m_sel       (m_sel),
    .s_ack       (s_ack),
    .s_req       (s_req),
    .s_cmd       (s_cmd),
    .m_ack       (m_ack),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    m_req = '0; m_cmd = '0; m_sel = '0; s_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_req = 2'b11; m_cmd = 2'b11; m_sel = 2'b00; s_ack = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_req, s_cmd, m_ack, grant, grant_idx, busy, timeout_err} !== 9'b0)
      $display("FAIL reset_outputs: got %b want 0", {s_req, s_cmd, m_ack, grant, grant_idx, busy, timeout_err});
    else n_pass++;
    reset = 1'b0;
    m_req = '0; m_cmd = '0; s_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    m_req = 2'b01; m_sel = 2'b00; m_cmd = 2'b01;
    @(negedge clk);
    n_checks++;
    if ({s_req, s_cmd, busy} !== 3'b111) $display("FAIL single_sreq_cmd_busy: got %b want 111", {s_req, s_cmd, busy});
    else n_pass++;
    n_checks++;
    if (grant !== 2'b01 || grant_idx !== 1'b0) $display("FAIL single_grant: got %b/%b want 01/0", grant, grant_idx);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_req !== 1'b1 || m_ack !== 2'b00) $display("FAIL single_hold: got s_req=%b m_ack=%b want 1/00", s_req, m_ack);
    else n_pass++;
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0; m_req = 2'b00;
    n_checks++;
    if ({m_ack, s_req, grant, busy} !== 6'b01_0_01_1)
      $display("FAIL single_done: got m_ack=%b s_req=%b grant=%b busy=%b want 01/0/01/1", m_ack, s_req, grant, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({m_ack, grant, busy, timeout_err} !== 6'b0)
      $display("FAIL single_idle: got m_ack=%b grant=%b busy=%b to=%b want 0", m_ack, grant, busy, timeout_err);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    bit ok;
    do_reset();
    m_req = 2'b11; m_sel = 2'b00; m_cmd = 2'b10;
    for (int k = 0; k < 4; k++) begin
      wait_sreq(ok);
      n_checks++;
      if (!ok || grant !== exp_g[k]) $display("FAIL rr_grant%0d: got %b (seen=%0d) want %b", k, grant, ok, exp_g[k]);
      else n_pass++;
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
      n_checks++;
      if (m_ack !== exp_g[k]) $display("FAIL rr_ack%0d: got %b want %b", k, m_ack, exp_g[k]);
      else n_pass++;
    end
    m_req = 2'b00;
  endtask

  task automatic test_other_slave();
    do_reset();
    m_req = 2'b10; m_sel = 2'b10; m_cmd = 2'b10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_ack = i[0];
      n_checks++;
      if ({s_req, grant, m_ack, busy} !== 6'b0)
        $display("FAIL other_slave_c%0d: got s_req=%b grant=%b m_ack=%b busy=%b want 0", i, s_req, grant, m_ack, busy);
      else n_pass++;
    end
    s_ack = 1'b0; m_req = 2'b00; m_sel = 2'b00;
  endtask

  task automatic test_timeout();
    int busy_cycles = 0;
    bit done = 1'b0;
    do_reset();
    m_req = 2'b01; m_sel = 2'b00;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m_ack !== 2'b00) done = 1'b1;
      else if (s_req === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (!done || busy_cycles != 16) $display("FAIL timeout_cycles: got %0d (fired=%0d) want 16", busy_cycles, done);
    else n_pass++;
    n_checks++;
    if ({m_ack, timeout_err, s_req} !== 4'b01_1_0)
      $display("FAIL timeout_pulse: got m_ack=%b to=%b s_req=%b want 01/1/0", m_ack, timeout_err, s_req);
    else n_pass++;
    m_req = 2'b11;
    @(negedge clk);
    n_checks++;
    if ({m_ack, timeout_err, grant} !== 5'b0)
      $display("FAIL timeout_one_cycle: got m_ack=%b to=%b grant=%b want 0", m_ack, timeout_err, grant);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10) $display("FAIL timeout_ptr_adv: got %b want 10", grant);
    else n_pass++;
    m_req = 2'b00;
  endtask

  task automatic test_ack_vs_timeout();
    bit ok;
    do_reset();
    m_req = 2'b01; m_sel = 2'b00;
    wait_sreq(ok);
    repeat (15) @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0; m_req = 2'b00;
    n_checks++;
    if (!ok || m_ack !== 2'b01 || timeout_err !== 1'b0)
      $display("FAIL ack_beats_timeout: got m_ack=%b to=%b want 01/0", m_ack, timeout_err);
    else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    m_req = 2'b11; m_sel = 2'b00;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01) $display("FAIL abort_first_grant: got %b want 01", grant);
    else n_pass++;
    @(negedge clk);
    m_req = 2'b10;
    @(negedge clk);
    n_checks++;
    if ({s_req, grant, m_ack, busy} !== 6'b0)
      $display("FAIL abort_release: got s_req=%b grant=%b m_ack=%b busy=%b want 0", s_req, grant, m_ack, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({s_req, grant, m_ack} !== 5'b1_10_00)
      $display("FAIL abort_next_grant: got s_req=%b grant=%b m_ack=%b want 1/10/00", s_req, grant, m_ack);
    else n_pass++;
    m_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    m_req = 2'b11; m_sel = 2'b00;
    wait_sreq(ok);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    wait_sreq(ok);
    n_checks++;
    if (!ok || grant !== 2'b10 || grant_idx !== 1'b1) $display("FAIL midreset_pre: got %b/%b want 10/1", grant, grant_idx);
    else n_pass++;
    s_ack = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; s_ack = 1'b0;
    n_checks++;
    if ({s_req, s_cmd, m_ack, grant, grant_idx, busy, timeout_err} !== 9'b0)
      $display("FAIL midreset_zero: got %b want 0", {s_req, s_cmd, m_ack, grant, grant_idx, busy, timeout_err});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01) $display("FAIL midreset_ptr0: got %b want 01", grant);
    else n_pass++;
    m_req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m_req = '0; m_cmd = '0; m_sel = '0; s_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_other_slave();
    test_timeout();
    test_ack_vs_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
